// File: rtl/regfile_write_arbiter.sv
// Write-side controller for the general register file: arbitrates CPU writeback and
// debug writes onto one registered write bus, and runs an init sweep over every register.
module regfile_write_arbiter #(
    parameter int                    DATA_WIDTH    = 16,
    parameter int                    NUM_REGS      = 8,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    parameter int                    CPU_FIXED_PRI = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_wr_valid,
    output logic                  cpu_wr_ready,
    input  logic [2:0]            cpu_wr_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wr_data,
    input  logic                  dbg_wr_valid,
    output logic                  dbg_wr_ready,
    input  logic [2:0]            dbg_wr_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wr_data,
    input  logic                  init_start,
    output logic                  init_busy,
    output logic                  init_done,
    output logic [DATA_WIDTH-1:0] bus_out,
    output logic [NUM_REGS-1:0]   ld_reg,
    output logic                  err_addr,
    output logic                  fsm_state
);

    localparam int                  IDX_W  = $clog2(NUM_REGS + 1);
    localparam logic [NUM_REGS-1:0] ONE    = NUM_REGS'(1);
    localparam logic                SIDE_CPU = 1'b0;
    localparam logic                SIDE_DBG = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic                    rr_last_q, rr_last_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   bus_q, bus_d;
    logic [NUM_REGS-1:0]     ld_q, ld_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;

    logic                    grant_cpu;
    logic                    grant_dbg;
    logic [2:0]              sel_addr;
    logic [DATA_WIDTH-1:0]   sel_data;

    // Handshake: a request transfers in the cycle where valid and ready are both high.
    // Ready is only ever raised on a side whose valid is high, never both at once, never
    // in INIT, never while init_start is high, and never while reset is asserted.
    always_comb begin
        grant_cpu = 1'b0;
        grant_dbg = 1'b0;
        if (!reset && state_q == ST_IDLE && !init_start) begin
            if (cpu_wr_valid && dbg_wr_valid) begin
                if (CPU_FIXED_PRI != 0 || rr_last_q == SIDE_DBG) begin
                    grant_cpu = 1'b1;
                end else begin
                    grant_dbg = 1'b1;
                end
            end else begin
                grant_cpu = cpu_wr_valid;
                grant_dbg = dbg_wr_valid;
            end
        end
    end

    always_comb begin
        sel_addr = cpu_wr_addr;
        sel_data = cpu_wr_data;
        if (grant_dbg) begin
            sel_addr = dbg_wr_addr;
            sel_data = dbg_wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        idx_d     = idx_q;
        bus_d     = bus_q;
        ld_d      = '0;
        err_d     = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (init_start) begin
                    // Register 0 is written straight out of IDLE so the sweep takes NUM_REGS cycles.
                    state_d = ST_INIT;
                    bus_d   = INIT_VALUE;
                    ld_d    = ONE;
                    idx_d   = IDX_W'(1);
                end else if (grant_cpu || grant_dbg) begin
                    rr_last_d = grant_dbg ? SIDE_DBG : SIDE_CPU;
                    if (int'(sel_addr) < NUM_REGS) begin
                        bus_d = sel_data;
                        ld_d  = ONE << sel_addr;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_INIT: begin
                if (idx_q < IDX_W'(NUM_REGS)) begin
                    bus_d = INIT_VALUE;
                    ld_d  = ONE << idx_q;
                    idx_d = idx_q + IDX_W'(1);
                end else begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rr_last_q <= SIDE_DBG;
            idx_q     <= '0;
            bus_q     <= '0;
            ld_q      <= '0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            idx_q     <= idx_d;
            bus_q     <= bus_d;
            ld_q      <= ld_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

    assign cpu_wr_ready = grant_cpu;
    assign dbg_wr_ready = grant_dbg;
    assign init_busy    = (state_q == ST_INIT);
    assign init_done    = done_q;
    assign bus_out      = bus_q;
    assign ld_reg       = ld_q;
    assign err_addr     = err_q;
    assign fsm_state    = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus pushes expected writes into a queue,
// a negedge monitor pops and compares every strobe the DUT puts on the write bus.
module tb_regfile_write_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cpu_wr_valid = 1'b0;
    logic [2:0]  cpu_wr_addr = '0;
    logic [15:0] cpu_wr_data = '0;
    logic        dbg_wr_valid = 1'b0;
    logic [2:0]  dbg_wr_addr = '0;
    logic [15:0] dbg_wr_data = '0;
    logic        init_start = 1'b0;

    logic        cpu_wr_ready, dbg_wr_ready, init_busy, init_done, err_addr, fsm_state;
    logic [15:0] bus_out;
    logic [7:0]  ld_reg;

    logic        fx_cpu_ready, fx_dbg_ready, fx_busy, fx_done, fx_err, fx_state;
    logic [15:0] fx_bus;
    logic [7:0]  fx_ld;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [23:0] exp_q[$];
    bit          chk_fx = 1'b0;

    regfile_write_arbiter #(
        .DATA_WIDTH(16), .NUM_REGS(8), .INIT_VALUE(16'hBEEF), .CPU_FIXED_PRI(0)
    ) dut (
        .clk(clk), .reset(reset),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(cpu_wr_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(dbg_wr_ready),
        .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
        .init_start(init_start), .init_busy(init_busy), .init_done(init_done),
        .bus_out(bus_out), .ld_reg(ld_reg), .err_addr(err_addr), .fsm_state(fsm_state)
    );

    regfile_write_arbiter #(
        .DATA_WIDTH(16), .NUM_REGS(8), .INIT_VALUE(16'h0000), .CPU_FIXED_PRI(1)
    ) dut_fx (
        .clk(clk), .reset(reset),
        .cpu_wr_valid(cpu_wr_valid), .cpu_wr_ready(fx_cpu_ready),
        .cpu_wr_addr(cpu_wr_addr), .cpu_wr_data(cpu_wr_data),
        .dbg_wr_valid(dbg_wr_valid), .dbg_wr_ready(fx_dbg_ready),
        .dbg_wr_addr(dbg_wr_addr), .dbg_wr_data(dbg_wr_data),
        .init_start(init_start), .init_busy(fx_busy), .init_done(fx_done),
        .bus_out(fx_bus), .ld_reg(fx_ld), .err_addr(fx_err), .fsm_state(fx_state)
    );

    // Clock / timeout
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete within 200000 time units");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every non-zero strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (ld_reg !== 8'h00) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {8'h00, ld_reg, bus_out}, 32'h0);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("write", {8'h00, ld_reg, bus_out}, {8'h00, e});
            end
        end
    end

    // Driver: one cycle of stimulus, readiness/status checks at the negedge.
    task automatic cyc(input logic cv, input logic [2:0] ca, input logic [15:0] cd,
                       input logic dv, input logic [2:0] da, input logic [15:0] dd,
                       input logic is, input logic exp_cr, input logic exp_dr,
                       input logic exp_busy, input logic exp_done);
        cpu_wr_valid = cv; cpu_wr_addr = ca; cpu_wr_data = cd;
        dbg_wr_valid = dv; dbg_wr_addr = da; dbg_wr_data = dd;
        init_start   = is;
        @(negedge clk);
        chk("cpu_wr_ready", {31'b0, cpu_wr_ready}, {31'b0, exp_cr});
        chk("dbg_wr_ready", {31'b0, dbg_wr_ready}, {31'b0, exp_dr});
        chk("init_busy", {31'b0, init_busy}, {31'b0, exp_busy});
        chk("init_done", {31'b0, init_done}, {31'b0, exp_done});
        chk("err_addr", {31'b0, err_addr}, 32'h0);
        if (chk_fx) begin
            chk("fx_cpu_ready", {31'b0, fx_cpu_ready}, {31'b0, cv});
            chk("fx_dbg_ready", {31'b0, fx_dbg_ready}, 32'h0);
        end
        if (exp_cr) exp_q.push_back({8'(8'h01 << ca), cd});
        if (exp_dr) exp_q.push_back({8'(8'h01 << da), dd});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic exp_busy, input logic exp_done);
        cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, exp_busy, exp_done);
    endtask

    initial begin
        // Reset with both valids high: readies must stay low.
        #1;
        reset = 1'b1;
        cpu_wr_valid = 1'b1;
        dbg_wr_valid = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_ld_reg", {24'b0, ld_reg}, 32'h0);
        chk("rst_bus_out", {16'b0, bus_out}, 32'h0);
        chk("rst_init_busy", {31'b0, init_busy}, 32'h0);
        chk("rst_init_done", {31'b0, init_done}, 32'h0);
        chk("rst_err_addr", {31'b0, err_addr}, 32'h0);
        chk("rst_cpu_ready", {31'b0, cpu_wr_ready}, 32'h0);
        chk("rst_dbg_ready", {31'b0, dbg_wr_ready}, 32'h0);
        chk("rst_state", {31'b0, fsm_state}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single CPU write, then bus holds after the strobe drops.
        cyc(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("bus_hold", {16'b0, bus_out}, 32'h1234);
        chk("ld_idle", {24'b0, ld_reg}, 32'h0);

        // Debug-only write leaves rr_last on the debug side.
        cyc(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Round-robin conflict; the fixed-priority instance must always pick the CPU.
        chk_fx = 1'b1;
        cyc(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3'd1, 16'hAAAA, 1'b1, 3'd2, 16'hBBBB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk_fx = 1'b0;
        idle(1'b0, 1'b0);

        // Back-to-back writes at the address extremes.
        cyc(1'b1, 3'd0, 16'h0001, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 3'd7, 16'h0777, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Init sweep with a CPU request pending from the same cycle; re-start is ignored.
        cyc(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 8; k++) exp_q.push_back({8'(8'h01 << k), 16'hBEEF});
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0, (k == 2), 1'b0, 1'b0, 1'b1, 1'b0);
        end
        cyc(1'b1, 3'd4, 16'h4444, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        // Reset during sweep cycle 3: strobes clear at once, no done pulse afterwards.
        cyc(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) exp_q.push_back({8'(8'h01 << k), 16'hBEEF});
        idle(1'b1, 1'b0);
        idle(1'b1, 1'b0);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_ld_reg", {24'b0, ld_reg}, 32'h0);
        chk("midrst_busy", {31'b0, init_busy}, 32'h0);
        chk("midrst_state", {31'b0, fsm_state}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        cyc(1'b1, 3'd6, 16'h6666, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);

        chk("exp_q_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
